// File: rtl/tmds_word_decoder_if.sv
// Signal bundle between the deserializer side and one TMDS channel word decoder.
interface tmds_word_decoder_if;
    // Free-running stream with no valid/ready: din carries a new word on every clk_pix
    // edge and every output is refreshed on every edge; there is no backpressure.
    logic [9:0] din;
    logic [7:0] dout;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] offset;
    logic [1:0] state_dbg;

    modport master (
        output din,
        input  dout, ctrl, de, locked, offset, state_dbg
    );

    modport slave (
        input  din,
        output dout, ctrl, de, locked, offset, state_dbg
    );
endinterface

// File: rtl/tmds_word_decoder.sv
// One DVI/TMDS receive channel: bit-slip word alignment on control tokens, then
// decode of each aligned 10-bit word into pixel data, control value and data enable.
module tmds_word_decoder #(
    parameter int LOCK_RUN     = 16,
    parameter int SEARCH_WORDS = 1024,
    parameter int LOSS_WORDS   = 4096
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    tmds_word_decoder_if.slave bus
);

    localparam int RUN_W  = $clog2(LOCK_RUN + 1);
    localparam int WIN_W  = $clog2(SEARCH_WORDS);
    localparam int LOSS_W = $clog2(LOSS_WORDS + 1);

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_RUN);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_RUN - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WORDS - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WORDS - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [9:0]        din_q;
    logic [9:0]        word_q;
    logic [RUN_W-1:0]  run_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [LOSS_W-1:0] loss_cnt;
    logic              settle_cnt;
    logic [3:0]        offset_q;
    logic              locked_q;
    logic [7:0]        dout_q;
    logic [1:0]        ctrl_q;
    logic              de_q;

    logic [19:0]       cat;
    logic [9:0]        window;
    logic              is_tok;
    logic [1:0]        tok_val;

    // din_q holds the older word, so the 20-bit view is {newer, older} and the
    // offset picks the 10 bits starting that many bits into the older word.
    assign cat    = {bus.din, din_q};
    assign window = 10'(cat >> offset_q);

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (word_q)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
    end

    // Undo the optional inversion (bit 9), then the XOR/XNOR transition chain (bit 8).
    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q    = 8'h00;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            state      <= ST_SEARCH;
            din_q      <= '0;
            word_q     <= '0;
            run_cnt    <= '0;
            win_cnt    <= '0;
            loss_cnt   <= '0;
            settle_cnt <= 1'b0;
            offset_q   <= '0;
            locked_q   <= 1'b0;
            dout_q     <= '0;
            ctrl_q     <= '0;
            de_q       <= 1'b0;
        end else begin
            din_q  <= bus.din;
            word_q <= window;

            if (state == ST_LOCKED) begin
                if (is_tok) begin
                    de_q   <= 1'b0;
                    dout_q <= '0;
                    ctrl_q <= tok_val;
                end else begin
                    de_q   <= 1'b1;
                    dout_q <= tmds_decode(word_q);
                end
            end else begin
                de_q   <= 1'b0;
                dout_q <= '0;
                ctrl_q <= '0;
            end

            case (state)
                ST_SEARCH: begin
                    if (is_tok && run_cnt == RUN_LAST) begin
                        state    <= ST_LOCKED;
                        locked_q <= 1'b1;
                        run_cnt  <= '0;
                        win_cnt  <= '0;
                        loss_cnt <= '0;
                    end else if (win_cnt == WIN_LAST) begin
                        offset_q   <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                        state      <= ST_SETTLE;
                        settle_cnt <= 1'b0;
                        run_cnt    <= '0;
                        win_cnt    <= '0;
                    end else begin
                        // win_cnt is below its last value here, so it cannot wrap.
                        win_cnt <= win_cnt + 1'b1;
                        if (!is_tok) begin
                            run_cnt <= '0;
                        end else if (run_cnt != RUN_MAX) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                end

                ST_SETTLE: begin
                    // Two cycles flush din_q/word_q words taken at the previous offset.
                    run_cnt <= '0;
                    win_cnt <= '0;
                    if (settle_cnt) begin
                        state      <= ST_SEARCH;
                        settle_cnt <= 1'b0;
                    end else begin
                        settle_cnt <= 1'b1;
                    end
                end

                ST_LOCKED: begin
                    if (is_tok) begin
                        loss_cnt <= '0;
                    end else if (loss_cnt == LOSS_LAST) begin
                        state    <= ST_SEARCH;
                        locked_q <= 1'b0;
                        loss_cnt <= '0;
                        run_cnt  <= '0;
                        win_cnt  <= '0;
                    end else begin
                        loss_cnt <= loss_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_SEARCH;
                end
            endcase
        end
    end

    assign bus.dout      = dout_q;
    assign bus.ctrl      = ctrl_q;
    assign bus.de        = de_q;
    assign bus.locked    = locked_q;
    assign bus.offset    = offset_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_tmds_word_decoder.sv
// Directed bench for tmds_word_decoder: reset, aligned and bit-slipped lock, decode
// table, loss of lock and reset while locked.
module tb_tmds_word_decoder;

    localparam int LOCK_RUN     = 16;
    localparam int SEARCH_WORDS = 1024;
    localparam int LOSS_WORDS   = 4096;

    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK1 = 10'b0010101011;
    localparam logic [9:0] DAT0 = 10'b0100000000;

    typedef struct {
        logic [9:0] din;
        logic [7:0] dout;
        logic [1:0] ctrl;
        logic       de;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_err;
    int   delay_bits;
    logic [9:0] prev_word;
    logic [10:0] exp_q[$];
    vec_t vecs[12];

    tmds_word_decoder_if bus();

    tmds_word_decoder #(
        .LOCK_RUN    (LOCK_RUN),
        .SEARCH_WORDS(SEARCH_WORDS),
        .LOSS_WORDS  (LOSS_WORDS)
    ) dut (
        .clk_pix  (clk),
        .rst_pix_n(rst_n),
        .bus      (bus)
    );

    // clock / reset-relative cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver: present one word of a stream delayed by delay_bits bits
    task automatic step(input logic [9:0] w);
        logic [19:0] c;
        @(negedge clk);
        c          = {w, prev_word};
        bus.din    = 10'(c >> (10 - delay_bits));
        prev_word  = w;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, {bus.dout, bus.ctrl, bus.de, bus.locked, bus.offset}, 32'h0);
    endtask

    initial begin
        int c_first;
        int last_step;
        int g;
        logic [10:0] e;

        n_checks   = 0;
        n_err      = 0;
        delay_bits = 0;
        prev_word  = '0;
        rst_n      = 1'b0;
        bus.din    = '0;

        vecs[0]  = '{10'b0100000000, 8'h00, 2'b00, 1'b1};
        vecs[1]  = '{10'b1111111111, 8'h00, 2'b00, 1'b1};
        vecs[2]  = '{10'b0011111111, 8'hFF, 2'b00, 1'b1};
        vecs[3]  = '{10'b0010101011, 8'h00, 2'b01, 1'b0};
        vecs[4]  = '{10'b0100000000, 8'h00, 2'b01, 1'b1};
        vecs[5]  = '{10'b0011111111, 8'hFF, 2'b01, 1'b1};
        vecs[6]  = '{10'b1010101011, 8'h00, 2'b11, 1'b0};
        vecs[7]  = '{10'b0101010100, 8'h00, 2'b10, 1'b0};
        vecs[8]  = '{10'b0100000001, 8'h03, 2'b10, 1'b1};
        vecs[9]  = '{10'b1000000000, 8'hFF, 2'b10, 1'b1};
        vecs[10] = '{10'b0110101010, 8'hFE, 2'b10, 1'b1};
        vecs[11] = '{10'b1101010100, 8'h00, 2'b00, 1'b0};

        // 1. reset with random input
        for (int i = 0; i < 4; i++) begin
            step(10'($urandom_range(0, 1023)));
            check_idle($sformatf("reset_cyc%0d", i));
        end
        rst_n = 1'b1;

        // 2. aligned token stream
        step(TOK0);
        c_first = cyc;
        g = 0;
        while (!bus.locked && g < LOCK_RUN + 10) begin
            step(TOK0);
            g++;
        end
        check("aligned_locked", bus.locked, 1);
        check_range("aligned_lock_cycles", cyc - c_first, LOCK_RUN, LOCK_RUN + 3);
        check("aligned_offset", bus.offset, 0);
        step(TOK0);
        check("aligned_ctrl_de", {bus.ctrl, bus.de}, 0);

        // 4. decode table, outputs three cycles after presentation
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                e = exp_q.pop_front();
                check($sformatf("decode%0d", i - 3), {bus.dout, bus.ctrl, bus.de}, e);
            end
            if (i < 12) begin
                bus.din   = vecs[i].din;
                prev_word = vecs[i].din;
                exp_q.push_back({vecs[i].dout, vecs[i].ctrl, vecs[i].de});
            end else begin
                bus.din   = TOK1;
                prev_word = TOK1;
            end
        end

        // 3. stream delayed by 3 bits: slip 0 -> 1 -> 2 -> 3, then lock
        rst_n      = 1'b0;
        delay_bits = 3;
        step(TOK0);
        step(TOK0);
        rst_n      = 1'b1;
        last_step  = 0;
        for (int s = 1; s <= 3; s++) begin
            g = 0;
            while (bus.offset == 4'(s - 1) && g < SEARCH_WORDS + 10) begin
                step(TOK0);
                g++;
            end
            check($sformatf("slip%0d_offset", s), bus.offset, s);
            check($sformatf("slip%0d_period", s), cyc - last_step,
                  (s == 1) ? SEARCH_WORDS : SEARCH_WORDS + 2);
            last_step = cyc;
        end
        g = 0;
        while (!bus.locked && g < LOCK_RUN + 10) begin
            step(TOK0);
            g++;
        end
        check("slip_locked", bus.locked, 1);
        check("slip_lock_offset", bus.offset, 3);
        step(TOK0);
        check("slip_ctrl_de", {bus.ctrl, bus.de}, 0);

        // 5. loss of lock at offset 3, then re-lock at the same offset
        step(DAT0);
        c_first = cyc;
        g = 0;
        while (bus.locked && g < LOSS_WORDS + 10) begin
            step(DAT0);
            g++;
            if (g == 10) check("loss_data_de_dout", {bus.dout, bus.de}, 9'h001);
        end
        check("loss_unlocked", bus.locked, 0);
        check_range("loss_cycles", cyc - c_first, LOSS_WORDS + 1, LOSS_WORDS + 3);
        check("loss_offset_kept", bus.offset, 3);
        step(DAT0);
        check("loss_de", bus.de, 0);
        step(TOK0);
        c_first = cyc;
        g = 0;
        while (!bus.locked && g < LOCK_RUN + 10) begin
            step(TOK0);
            g++;
        end
        check("relock_locked", bus.locked, 1);
        check_range("relock_cycles", cyc - c_first, LOCK_RUN, LOCK_RUN + 3);
        check("relock_offset", bus.offset, 3);

        // 6. one-cycle reset while locked
        step(TOK0);
        rst_n = 1'b0;
        step(TOK0);
        check_idle("midreset_outputs");
        rst_n = 1'b1;
        g = 0;
        while (bus.offset == 4'd0 && g < SEARCH_WORDS + 10) begin
            step(TOK0);
            g++;
            if (g == 20) check("midreset_no_lock", bus.locked, 0);
        end
        check("midreset_first_slip", bus.offset, 1);
        check("midreset_slip_cycle", cyc, SEARCH_WORDS);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
